ks_control_unit_mc: RTL and testbench
=====================================

// Module: ks_control_unit_mc
// PURPOSE
// - Multi-cycle K&S control FSM, parametrised successor of the single-path unit.
// - Adds RAM wait states, all six conditional branches and 5-op ALU encoding.
// - Adds a retired-instruction counter.
// - Sits between decoder/flags register and datapath (PC, IR, regfile, ALU, RAM).
// PARAMETERS
// - MEM_WAIT  1   extra cycles RAM needs before read data valid (0..15; 0 = no wait state)
// - OP_W      3   width of ALU operation bus
// - CNT_W     16  width of retired-instruction counter
// PORTS
// - clk                  in   1      clock
// - rst                  in   1      synchronous reset, active-high
// - decoded_instruction  in   enum   decoder output (k_and_s_pkg), valid in DECODE
// - zero_op              in   1      registered zero flag
// - neg_op               in   1      registered negative flag
// - unsigned_overflow    in   1      registered unsigned overflow flag
// - signed_overflow      in   1      registered signed overflow flag
// - branch               out  1      PC source = branch target
// - pc_enable            out  1      PC load
// - ir_enable            out  1      IR load
// - write_reg_enable     out  1      regfile write
// - addr_sel             out  1      RAM address = operand address (0 = PC)
// - c_sel                out  1      regfile write data: 0 = ALU, 1 = RAM
// - operation            out  OP_W   ALU operation code
// - flags_reg_enable     out  1      flags register load
// - ram_write_enable     out  1      RAM write strobe
// - halt                 out  1      program finished
// - illegal_instr        out  1      one-cycle pulse: unrecognised instruction decoded
// - instr_count          out  CNT_W  instructions fetched since reset, saturating
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-high.
// - Reset: state <= FETCH, wait counter <= 0, instr_count <= 0.
//   All strobes are 0 during/after reset. rst wins over any in-flight op, including mid-wait.
// - States: FETCH, FETCH_WAIT, IR_LOAD, DECODE, LOAD_WAIT, LOAD_WB, HALTED.
// - Output defaults: all 0 except operation = OP_PASS. Outputs are combinational from state + inputs.
// - FETCH: addr_sel=0.
//   -> FETCH_WAIT if MEM_WAIT>0 (counter <= MEM_WAIT-1), else -> IR_LOAD.
// - FETCH_WAIT: addr_sel=0; counter decrements; -> IR_LOAD when counter==0.
// - IR_LOAD: ir_enable=1, pc_enable=1; instr_count++ (holds at all-ones); -> DECODE.
// - DECODE, per decoded_instruction:
//   - MOVE/ADD/SUB/AND/OR: operation = OP_PASS/ADD/SUB/AND/OR; c_sel=0; write_reg_enable=1.
//     flags_reg_enable=1 for all except MOVE. -> FETCH.
//   - LOAD: addr_sel=1 -> LOAD_WAIT (MEM_WAIT>0, counter <= MEM_WAIT-1) else -> LOAD_WB.
//   - STORE: addr_sel=1, ram_write_enable=1 for exactly this cycle -> FETCH.
//   - BRANCH: branch=1, pc_enable=1 -> FETCH.
//   - BZERO/BNZERO: taken if zero_op is 1/0.
//   - BNEG/BNNEG: taken if neg_op is 1/0.
//   - BOV/BNOV: taken if (signed_overflow|unsigned_overflow) is 1/0.
//     taken -> branch=1, pc_enable=1; not taken -> no strobes. -> FETCH either way.
//   - HALT -> HALTED.
//   - any other value (incl. NOP): illegal_instr=1 only if not NOP; no strobes; -> FETCH.
// - LOAD_WAIT: addr_sel=1; counter decrements; -> LOAD_WB at 0.
// - LOAD_WB: addr_sel=1, c_sel=1, write_reg_enable=1; flags untouched -> FETCH.
// - HALTED: halt=1 every cycle; no other strobes; exit only via rst.
// - Latency, instructions to next FETCH:
//   - ALU/branch/store: 3+MEM_WAIT cycles.
//   - LOAD: 4+2*MEM_WAIT cycles.
// - Flags are sampled in DECODE only. A flag update from the previous ALU op is visible, since the flags register loads at its DECODE edge.
// STRUCTURE
// - k_and_s_pkg gains:
//   - OP_PASS=0, OP_ADD=1, OP_SUB=2, OP_AND=3, OP_OR=4 (width OP_W);
//   - ks_cu_state_t enum.
// - decoded_instruction_type is reused unchanged.
// - Sub-module ks_branch_eval: combinational, (decoded_instruction, flags) -> taken.
// - Wait counter: $clog2(MEM_WAIT+1) bits, shared by both wait states.
// TESTING
// - Reset: hold rst 2 cycles mid-LOAD_WAIT -> next cycle FETCH, all strobes 0, instr_count=0.
// - ADD, MEM_WAIT=1: FETCH,FETCH_WAIT,IR_LOAD,DECODE.
//   DECODE shows operation=1, write_reg_enable=1, flags_reg_enable=1; instr_count=1.
// - OR -> operation=4; MOVE -> operation=0, flags_reg_enable=0.
// - LOAD, MEM_WAIT=3: 3 LOAD_WAIT cycles with addr_sel=1.
//   Then one cycle c_sel=1 and write_reg_enable=1; total 10 cycles between FETCH entries.
// - Conditional branches:
//   - BZERO with zero_op=1 -> branch=pc_enable=1; with zero_op=0 -> no strobes.
//   - BNOV with signed_overflow=1 -> not taken.
// - HALT -> halt=1 held 20 cycles, instr_count frozen; rst -> halt=0.
// - CNT_W=4: 17 NOPs -> instr_count saturates at 15; invalid code -> illegal_instr one-cycle pulse.

Source files
------------

// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S control unit and its helpers.
package k_and_s_pkg;

    // Decoder output; 5-bit encoding leaves codes 16..31 unassigned (illegal).
    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd15
    } decoded_instruction_type;

    // ALU operation codes, cast to the operation bus width at the use site.
    localparam int unsigned OP_PASS = 0;
    localparam int unsigned OP_ADD  = 1;
    localparam int unsigned OP_SUB  = 2;
    localparam int unsigned OP_AND  = 3;
    localparam int unsigned OP_OR   = 4;

    // Control FSM states.
    typedef enum logic [2:0] {
        ST_FETCH      = 3'd0,
        ST_FETCH_WAIT = 3'd1,
        ST_IR_LOAD    = 3'd2,
        ST_DECODE     = 3'd3,
        ST_LOAD_WAIT  = 3'd4,
        ST_LOAD_WB    = 3'd5,
        ST_HALTED     = 3'd6
    } ks_cu_state_t;

endpackage

// File: rtl/ks_branch_eval.sv
// Branch condition evaluation: decides whether the decoded branch is taken.
module ks_branch_eval
    import k_and_s_pkg::*;
(
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    taken_c
);

    logic ovf_c;
    assign ovf_c = signed_overflow | unsigned_overflow;

    // Map each branch flavour onto its flag test; non-branches are never taken.
    always_comb begin
        taken_c = 1'b0;
        case (decoded_instruction)
            I_BRANCH: taken_c = 1'b1;
            I_BZERO:  taken_c = zero_op;
            I_BNZERO: taken_c = ~zero_op;
            I_BNEG:   taken_c = neg_op;
            I_BNNEG:  taken_c = ~neg_op;
            I_BOV:    taken_c = ovf_c;
            I_BNOV:   taken_c = ~ovf_c;
            default:  taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/ks_control_unit_mc.sv
// Multi-cycle K&S control FSM with RAM wait states, conditional branches
// and a saturating retired-instruction counter.
module ks_control_unit_mc
    import k_and_s_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned OP_W     = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    write_reg_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [OP_W-1:0]         operation,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt,
    output logic                    illegal_instr,
    output logic [CNT_W-1:0]        instr_count
);

    // Keep at least one bit so MEM_WAIT=0 still elaborates cleanly.
    localparam int unsigned WC_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

    ks_cu_state_t     state_q;
    ks_cu_state_t     state_d;
    logic [WC_W-1:0]  wait_q;
    logic [WC_W-1:0]  wait_d;
    logic [CNT_W-1:0] count_q;
    logic             count_inc_c;
    logic             taken_c;

    assign instr_count = count_q;

    ks_branch_eval u_branch_eval (
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .taken_c             (taken_c)
    );

    // State, shared wait counter and saturating instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (count_inc_c && (count_q != '1)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Next-state and strobe decode; reset forces every strobe low.
    always_comb begin
        state_d          = state_q;
        wait_d           = wait_q;
        count_inc_c      = 1'b0;
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        write_reg_enable = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = OP_W'(OP_PASS);
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;
        illegal_instr    = 1'b0;

        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    if (MEM_WAIT > 0) begin
                        state_d = ST_FETCH_WAIT;
                        wait_d  = WC_W'(MEM_WAIT - 1);
                    end else begin
                        state_d = ST_IR_LOAD;
                    end
                end

                ST_FETCH_WAIT: begin
                    if (wait_q == '0) begin
                        state_d = ST_IR_LOAD;
                    end else begin
                        wait_d = wait_q - WC_W'(1);
                    end
                end

                ST_IR_LOAD: begin
                    ir_enable   = 1'b1;
                    pc_enable   = 1'b1;
                    count_inc_c = 1'b1;
                    state_d     = ST_DECODE;
                end

                ST_DECODE: begin
                    state_d = ST_FETCH;
                    case (decoded_instruction)
                        I_MOVE: begin
                            write_reg_enable = 1'b1;
                        end
                        I_ADD: begin
                            operation        = OP_W'(OP_ADD);
                            write_reg_enable = 1'b1;
                            flags_reg_enable = 1'b1;
                        end
                        I_SUB: begin
                            operation        = OP_W'(OP_SUB);
                            write_reg_enable = 1'b1;
                            flags_reg_enable = 1'b1;
                        end
                        I_AND: begin
                            operation        = OP_W'(OP_AND);
                            write_reg_enable = 1'b1;
                            flags_reg_enable = 1'b1;
                        end
                        I_OR: begin
                            operation        = OP_W'(OP_OR);
                            write_reg_enable = 1'b1;
                            flags_reg_enable = 1'b1;
                        end
                        I_LOAD: begin
                            addr_sel = 1'b1;
                            if (MEM_WAIT > 0) begin
                                state_d = ST_LOAD_WAIT;
                                wait_d  = WC_W'(MEM_WAIT - 1);
                            end else begin
                                state_d = ST_LOAD_WB;
                            end
                        end
                        I_STORE: begin
                            addr_sel         = 1'b1;
                            ram_write_enable = 1'b1;
                        end
                        I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
                        I_BNNEG, I_BOV, I_BNOV: begin
                            branch    = taken_c;
                            pc_enable = taken_c;
                        end
                        I_HALT: begin
                            state_d = ST_HALTED;
                        end
                        I_NOP: begin
                            state_d = ST_FETCH;
                        end
                        default: begin
                            illegal_instr = 1'b1;
                        end
                    endcase
                end

                ST_LOAD_WAIT: begin
                    addr_sel = 1'b1;
                    if (wait_q == '0) begin
                        state_d = ST_LOAD_WB;
                    end else begin
                        wait_d = wait_q - WC_W'(1);
                    end
                end

                ST_LOAD_WB: begin
                    addr_sel         = 1'b1;
                    c_sel            = 1'b1;
                    write_reg_enable = 1'b1;
                    state_d          = ST_FETCH;
                end

                ST_HALTED: begin
                    halt = 1'b1;
                end

                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ks_control_unit_mc.sv
// Scoreboard bench: three control-unit instances (MEM_WAIT=1, MEM_WAIT=3,
// MEM_WAIT=0 with a 4-bit counter) driven with directed instruction streams.
module tb_ks_control_unit_mc;
    import k_and_s_pkg::*;

    typedef struct packed {
        logic        branch;
        logic        pc_enable;
        logic        ir_enable;
        logic        write_reg_enable;
        logic        addr_sel;
        logic        c_sel;
        logic [2:0]  operation;
        logic        flags_reg_enable;
        logic        ram_write_enable;
        logic        halt;
        logic        illegal_instr;
        logic [15:0] instr_count;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decoded_instruction_type ins [3];
    logic zf [3];
    logic nf [3];
    logic uf [3];
    logic sf [3];

    logic        br   [3];
    logic        pce  [3];
    logic        ire  [3];
    logic        wre  [3];
    logic        asel [3];
    logic        csel [3];
    logic [2:0]  op   [3];
    logic        fre  [3];
    logic        rwe  [3];
    logic        hlt  [3];
    logic        ill  [3];
    logic [15:0] c16  [3];
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [3:0]  cnt2;
    out_t        act  [3];

    assign c16[0] = cnt0;
    assign c16[1] = cnt1;
    assign c16[2] = {12'd0, cnt2};

    for (genvar g = 0; g < 3; g++) begin : g_act
        assign act[g] = {br[g], pce[g], ire[g], wre[g], asel[g], csel[g], op[g],
                         fre[g], rwe[g], hlt[g], ill[g], c16[g]};
    end

    ks_control_unit_mc #(.MEM_WAIT(1), .OP_W(3), .CNT_W(16)) u_mw1 (
        .clk(clk), .rst(rst), .decoded_instruction(ins[0]),
        .zero_op(zf[0]), .neg_op(nf[0]), .unsigned_overflow(uf[0]), .signed_overflow(sf[0]),
        .branch(br[0]), .pc_enable(pce[0]), .ir_enable(ire[0]), .write_reg_enable(wre[0]),
        .addr_sel(asel[0]), .c_sel(csel[0]), .operation(op[0]), .flags_reg_enable(fre[0]),
        .ram_write_enable(rwe[0]), .halt(hlt[0]), .illegal_instr(ill[0]), .instr_count(cnt0)
    );

    ks_control_unit_mc #(.MEM_WAIT(3), .OP_W(3), .CNT_W(16)) u_mw3 (
        .clk(clk), .rst(rst), .decoded_instruction(ins[1]),
        .zero_op(zf[1]), .neg_op(nf[1]), .unsigned_overflow(uf[1]), .signed_overflow(sf[1]),
        .branch(br[1]), .pc_enable(pce[1]), .ir_enable(ire[1]), .write_reg_enable(wre[1]),
        .addr_sel(asel[1]), .c_sel(csel[1]), .operation(op[1]), .flags_reg_enable(fre[1]),
        .ram_write_enable(rwe[1]), .halt(hlt[1]), .illegal_instr(ill[1]), .instr_count(cnt1)
    );

    ks_control_unit_mc #(.MEM_WAIT(0), .OP_W(3), .CNT_W(4)) u_mw0 (
        .clk(clk), .rst(rst), .decoded_instruction(ins[2]),
        .zero_op(zf[2]), .neg_op(nf[2]), .unsigned_overflow(uf[2]), .signed_overflow(sf[2]),
        .branch(br[2]), .pc_enable(pce[2]), .ir_enable(ire[2]), .write_reg_enable(wre[2]),
        .addr_sel(asel[2]), .c_sel(csel[2]), .operation(op[2]), .flags_reg_enable(fre[2]),
        .ram_write_enable(rwe[2]), .halt(hlt[2]), .illegal_instr(ill[2]), .instr_count(cnt2)
    );

    // Scoreboard queues, one per instance.
    out_t q0 [$];
    out_t q1 [$];
    out_t q2 [$];

    int checks   = 0;
    int failures = 0;
    int unsigned cnt  [3];
    int unsigned cmax [3];

    task automatic chk(input string nm, input out_t a, input out_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, a, e);
        end
    endtask

    // Monitor: every cycle with a pending expectation, compare mid-cycle.
    out_t m_e;
    always @(negedge clk) begin
        if (q0.size() > 0) begin
            m_e = q0.pop_front();
            chk("mw1", act[0], m_e);
        end
        if (q1.size() > 0) begin
            m_e = q1.pop_front();
            chk("mw3", act[1], m_e);
        end
        if (q2.size() > 0) begin
            m_e = q2.pop_front();
            chk("mw0_cnt4", act[2], m_e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input out_t e);
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic cyc(input int id, input out_t e);
        push(id, e);
        tick();
    endtask

    function automatic out_t base(input int unsigned c);
        out_t e;
        e = '0;
        e.instr_count = 16'(c);
        return e;
    endfunction

    function automatic out_t alu_e(input logic [2:0] o, input logic f);
        out_t e;
        e = '0;
        e.operation        = o;
        e.write_reg_enable = 1'b1;
        e.flags_reg_enable = f;
        return e;
    endfunction

    function automatic out_t br_e();
        out_t e;
        e = '0;
        e.branch    = 1'b1;
        e.pc_enable = 1'b1;
        return e;
    endfunction

    // Fetch (+waits), IR load, then the hand-written DECODE expectation.
    task automatic do_instr(input int id, input int nwait, input decoded_instruction_type i,
                            input logic z, input logic n, input logic u, input logic s,
                            input out_t d);
        out_t e;
        ins[id] = i;
        zf[id]  = z;
        nf[id]  = n;
        uf[id]  = u;
        sf[id]  = s;
        for (int k = 0; k <= nwait; k++) cyc(id, base(cnt[id]));
        e = base(cnt[id]);
        e.ir_enable = 1'b1;
        e.pc_enable = 1'b1;
        cyc(id, e);
        if (cnt[id] != cmax[id]) cnt[id]++;
        d.instr_count = 16'(cnt[id]);
        cyc(id, d);
    endtask

    initial begin
        out_t d;
        out_t e;
        for (int k = 0; k < 3; k++) begin
            ins[k] = I_NOP;
            zf[k] = 1'b0; nf[k] = 1'b0; uf[k] = 1'b0; sf[k] = 1'b0;
            cnt[k] = 0;
        end
        cmax[0] = 65535; cmax[1] = 65535; cmax[2] = 15;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // MEM_WAIT=1: ALU ops, branches, store, NOP, halt.
        do_instr(0, 1, I_ADD,   0, 0, 0, 0, alu_e(3'd1, 1'b1));
        do_instr(0, 1, I_OR,    0, 0, 0, 0, alu_e(3'd4, 1'b1));
        do_instr(0, 1, I_MOVE,  0, 0, 0, 0, alu_e(3'd0, 1'b0));
        do_instr(0, 1, I_BZERO, 1, 0, 0, 0, br_e());
        do_instr(0, 1, I_BZERO, 0, 0, 0, 0, '0);
        do_instr(0, 1, I_BNOV,  0, 0, 0, 1, '0);
        d = '0; d.addr_sel = 1'b1; d.ram_write_enable = 1'b1;
        do_instr(0, 1, I_STORE, 0, 0, 0, 0, d);
        do_instr(0, 1, I_SUB,   0, 0, 0, 0, alu_e(3'd2, 1'b1));
        do_instr(0, 1, I_AND,   0, 0, 0, 0, alu_e(3'd3, 1'b1));
        do_instr(0, 1, I_NOP,   0, 0, 0, 0, '0);
        do_instr(0, 1, I_HALT,  0, 0, 0, 0, '0);
        ins[0] = I_ADD;
        for (int k = 0; k < 20; k++) begin
            e = base(cnt[0]);
            e.halt = 1'b1;
            cyc(0, e);
        end

        // Reset releases HALTED; strobes and halt low while rst is high.
        rst = 1'b1;
        cyc(0, base(cnt[0]));
        cyc(0, base(0));
        rst = 1'b0;
        cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
        push(0, base(0));

        // MEM_WAIT=3 load: 3 wait cycles, then write-back; 10 cycles total.
        d = '0; d.addr_sel = 1'b1;
        do_instr(1, 3, I_LOAD, 0, 0, 0, 0, d);
        for (int k = 0; k < 3; k++) begin
            e = base(cnt[1]); e.addr_sel = 1'b1; cyc(1, e);
        end
        e = base(cnt[1]); e.addr_sel = 1'b1; e.c_sel = 1'b1; e.write_reg_enable = 1'b1;
        cyc(1, e);

        // Second load interrupted by a 2-cycle reset in the middle of LOAD_WAIT.
        do_instr(1, 3, I_LOAD, 0, 0, 0, 0, d);
        e = base(cnt[1]); e.addr_sel = 1'b1; cyc(1, e);
        rst = 1'b1;
        cyc(1, base(cnt[1]));
        cnt[1] = 0;
        cyc(1, base(0));
        rst = 1'b0;
        cnt[2] = 0;
        cyc(1, base(0));
        cyc(1, base(0));

        // Re-align instance 2 with a fresh reset, then counter saturation.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt[2] = 0;
        for (int k = 0; k < 17; k++) do_instr(2, 0, I_NOP, 0, 0, 0, 0, '0);
        d = '0; d.illegal_instr = 1'b1;
        do_instr(2, 0, decoded_instruction_type'(5'd20), 0, 0, 0, 0, d);
        do_instr(2, 0, I_BRANCH, 0, 0, 0, 0, br_e());
        do_instr(2, 0, I_BNNEG,  0, 0, 0, 0, br_e());
        do_instr(2, 0, I_BNEG,   0, 0, 0, 0, '0);
        do_instr(2, 0, I_BOV,    0, 0, 1, 0, br_e());
        do_instr(2, 0, I_BNZERO, 0, 0, 0, 0, br_e());
        do_instr(2, 0, I_ADD,    0, 0, 0, 0, alu_e(3'd1, 1'b1));
        cyc(2, base(cnt[2]));

        tick();
        checks++;
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d pending expected=0",
                     q0.size() + q1.size() + q2.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
